// File: rtl/mem_defs.sv
// Shared definitions for the MEM-stage data-bus controller.
// Holds the access-size encodings, the controller FSM state type and a
// misalignment helper used when MEM_ALE_EN is defined.
package mem_defs;

  // Access size encodings; 2'd3 is reserved and handled as a word.
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } state_e;

  // Half must sit on an even address, word (and reserved size) on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = a[0];
      default: mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for the data bus.
// Ports:
//   size, addr_lo   - access size and address bits [1:0]
//   wdata           - right-aligned store data
//   rdata           - raw 32-bit read word from the bus
//   unsigned_ld     - zero-extend loads when set, sign-extend otherwise
//   wstrb           - byte strobes for a store
//   wdata_rep       - store data replicated across the lanes
//   rdata_ext       - selected and extended load data
module mem_lane_align
  import mem_defs::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        unsigned_ld,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rdata;
    shifted   = rdata >> {addr_lo, 3'b000};
    case (size)
      MEM_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{shifted[7] & ~unsigned_ld}}, shifted[7:0]};
      end
      MEM_H: begin
        // Odd half addresses get no strobes at all.
        case (addr_lo)
          2'b00:   wstrb = 4'b0011;
          2'b10:   wstrb = 4'b1100;
          default: wstrb = 4'b0000;
        endcase
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{shifted[15] & ~unsigned_ld}}, shifted[15:0]};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller for the LA32R pipeline.
// Accepts one load/store at a time, drives the SRAM-like data_sram_* bus and
// returns aligned, extended load data to write-back.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_*                 - request from the MEM stage (valid/ready handshake)
//   flush                 - pipeline flush; cancels the in-flight access
//   resp_*                - response to WB (valid/ready), load data, ALE flag
//   data_sram_*           - data bus request/address/data handshake
// Build option: define MEM_ALE_EN to trap misaligned accesses locally
// (resp_ale = 1, no bus access); otherwise they go to the bus unchanged.
module mem_access_ctrl
  import mem_defs::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_ale,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata
);

  state_e            state_q;
  logic              cancel_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
`ifdef MEM_ALE_EN
  logic              ale_q;
`endif

  logic [3:0]        strb;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rdata_ext;

  // Alignment works on latched fields so bus outputs stay stable until addr_ok.
  mem_lane_align u_lane_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (data_sram_rdata),
    .unsigned_ld (unsigned_q),
    .wstrb       (strb),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cancel_q   <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
`ifdef MEM_ALE_EN
      ale_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          cancel_q <= 1'b0;
          if (req_valid && !flush) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rdata_q    <= '0;
`ifdef MEM_ALE_EN
            if (is_misaligned(req_size, req_addr[1:0])) begin
              ale_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              ale_q   <= 1'b0;
              state_q <= StReq;
            end
`else
            state_q <= StReq;
`endif
          end
        end
        StReq: begin
          if (flush) cancel_q <= 1'b1;
          if (data_sram_addr_ok) begin
            // Same-cycle data_ok completes the access immediately.
            if (data_sram_data_ok) begin
              if (cancel_q || flush) begin
                cancel_q <= 1'b0;
                state_q  <= StIdle;
              end else begin
                rdata_q <= we_q ? '0 : rdata_ext;
                state_q <= StResp;
              end
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (flush) cancel_q <= 1'b1;
          if (data_sram_data_ok) begin
            if (cancel_q || flush) begin
              cancel_q <= 1'b0;
              state_q  <= StIdle;
            end else begin
              rdata_q <= we_q ? '0 : rdata_ext;
              state_q <= StResp;
            end
          end
        end
        StResp: begin
          if (flush || resp_ready) state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready       = (state_q == StIdle);
  assign resp_valid      = (state_q == StResp);
  assign resp_rdata      = rdata_q;
  assign data_sram_req   = (state_q == StReq);
  assign data_sram_wr    = we_q;
  assign data_sram_size  = size_q;
  assign data_sram_wstrb = we_q ? strb : 4'b0000;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_rep;
`ifdef MEM_ALE_EN
  assign resp_ale        = ale_q;
`else
  assign resp_ale        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_ale;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_size          (req_size),
    .req_unsigned      (req_unsigned),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .flush             (flush),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_ale          (resp_ale),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; flush = 1'b0; resp_ready = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    tick(); tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_sram_req", {31'd0, data_sram_req}, 32'd0);
    chk("rst_wstrb", {28'd0, data_sram_wstrb}, 32'd0);
    chk("rst_addr", data_sram_addr, 32'd0);
    chk("rst_ale", {31'd0, resp_ale}, 32'd0);
    reset = 1'b0;
    tick();

    // Flush with req_valid in idle: nothing accepted.
    drive_req(1'b1, 2'd2, 1'b0, 32'h1C00_0000, 32'h1111_1111);
    flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_req", {31'd0, data_sram_req}, 32'd0);
    chk("flush_idle_ready", {31'd0, req_ready}, 32'd1);

    // Store byte at lane 3.
    drive_req(1'b1, 2'd0, 1'b0, 32'h1C00_0003, 32'h0000_00AB);
    tick();
    req_valid = 1'b0;
    chk("sb_req", {31'd0, data_sram_req}, 32'd1);
    chk("sb_wr", {31'd0, data_sram_wr}, 32'd1);
    chk("sb_wstrb", {28'd0, data_sram_wstrb}, 32'h8);
    chk("sb_wdata", data_sram_wdata, 32'hABAB_ABAB);
    chk("sb_addr", data_sram_addr, 32'h1C00_0003);
    chk("sb_size", {30'd0, data_sram_size}, 32'd0);
    chk("sb_ready", {31'd0, req_ready}, 32'd0);
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0;
    chk("sb_wait_req", {31'd0, data_sram_req}, 32'd0);
    chk("sb_wait_valid", {31'd0, resp_valid}, 32'd0);
    data_sram_data_ok = 1'b1;
    tick();
    data_sram_data_ok = 1'b0;
    chk("sb_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("sb_resp_rdata", resp_rdata, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("sb_done_valid", {31'd0, resp_valid}, 32'd0);
    chk("sb_done_ready", {31'd0, req_ready}, 32'd1);

    // Load half signed at lane 2, same-cycle addr_ok/data_ok, response held.
    drive_req(1'b0, 2'd1, 1'b0, 32'h1C00_0002, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("lh_wstrb", {28'd0, data_sram_wstrb}, 32'd0);
    chk("lh_wr", {31'd0, data_sram_wr}, 32'd0);
    chk("lh_size", {30'd0, data_sram_size}, 32'd1);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_1234;
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    chk("lh_valid", {31'd0, resp_valid}, 32'd1);
    chk("lh_rdata", resp_rdata, 32'hFFFF_8001);
    tick();
    chk("lh_hold_valid", {31'd0, resp_valid}, 32'd1);
    chk("lh_hold_rdata", resp_rdata, 32'hFFFF_8001);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Load half unsigned, minimum latency.
    drive_req(1'b0, 2'd1, 1'b1, 32'h1C00_0002, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("lhu_req", {31'd0, data_sram_req}, 32'd1);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_1234;
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    chk("lhu_valid", {31'd0, resp_valid}, 32'd1);
    chk("lhu_rdata", resp_rdata, 32'h0000_8001);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Bus stall: store word held for 5 cycles without addr_ok.
    drive_req(1'b1, 2'd2, 1'b0, 32'h1C00_0010, 32'h1234_5678);
    tick();
    drive_req(1'b0, 2'd0, 1'b1, 32'h0, 32'h0);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {31'd0, data_sram_req}, 32'd1);
      chk("stall_addr", data_sram_addr, 32'h1C00_0010);
      chk("stall_wstrb", {28'd0, data_sram_wstrb}, 32'hF);
      chk("stall_wdata", data_sram_wdata, 32'h1234_5678);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    chk("stall_valid", {31'd0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Flush in WAIT: no response, next request accepted right away.
    drive_req(1'b0, 2'd0, 1'b0, 32'h1C00_0001, 32'h0);
    tick();
    req_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555;
    tick();
    data_sram_data_ok = 1'b0;
    chk("fw_valid", {31'd0, resp_valid}, 32'd0);
    chk("fw_ready", {31'd0, req_ready}, 32'd1);
    drive_req(1'b0, 2'd0, 1'b0, 32'h1C00_0001, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("fw_next_req", {31'd0, data_sram_req}, 32'd1);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_8500;
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    chk("lb_rdata", resp_rdata, 32'hFFFF_FF85);

    // Flush in RESP drops the response.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fr_valid", {31'd0, resp_valid}, 32'd0);
    chk("fr_ready", {31'd0, req_ready}, 32'd1);

    // Misaligned word load at lane 1.
    drive_req(1'b0, 2'd2, 1'b0, 32'h1C00_0001, 32'h0);
    tick();
    req_valid = 1'b0;
`ifdef MEM_ALE_EN
    chk("ale_req", {31'd0, data_sram_req}, 32'd0);
    chk("ale_valid", {31'd0, resp_valid}, 32'd1);
    chk("ale_flag", {31'd0, resp_ale}, 32'd1);
    chk("ale_rdata", resp_rdata, 32'd0);
`else
    chk("mis_req", {31'd0, data_sram_req}, 32'd1);
    chk("mis_wstrb", {28'd0, data_sram_wstrb}, 32'd0);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    chk("mis_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("mis_ale", {31'd0, resp_ale}, 32'd0);
`endif
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Store half at lane 2.
    drive_req(1'b1, 2'd1, 1'b0, 32'h1C00_0006, 32'h0000_BEEF);
    tick();
    req_valid = 1'b0;
    chk("sh_wstrb", {28'd0, data_sram_wstrb}, 32'hC);
    chk("sh_wdata", data_sram_wdata, 32'hBEEF_BEEF);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    resp_ready = 1'b1;
    tick();

    // Back-to-back: bus always ready, resp_ready high, 3 cycles per access.
    drive_req(1'b0, 2'd0, 1'b1, 32'h1C00_0000, 32'h0);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_00F0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("b2b_req", {31'd0, data_sram_req}, 32'd1);
      tick();
      chk("b2b_valid", {31'd0, resp_valid}, 32'd1);
      chk("b2b_rdata", resp_rdata, 32'h0000_00F0);
      tick();
      chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    end
    req_valid = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; resp_ready = 1'b0;
    tick();

    // Reset in the middle of REQ, then a stale data_ok.
    drive_req(1'b1, 2'd2, 1'b0, 32'h1C00_0020, 32'hCAFE_F00D);
    tick();
    req_valid = 1'b0;
    chk("mr_req", {31'd0, data_sram_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_ready", {31'd0, req_ready}, 32'd1);
    chk("mr_sram_req", {31'd0, data_sram_req}, 32'd0);
    data_sram_data_ok = 1'b1;
    tick();
    data_sram_data_ok = 1'b0;
    chk("mr_stale_valid", {31'd0, resp_valid}, 32'd0);
    chk("mr_stale_ready", {31'd0, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses from the LA32R MEM stage onto the SRAM-like data bus.
- Latches one load/store request at a time and builds the byte write strobes and lane-replicated store data.
- Drives the bus request/address/data handshake, then returns the aligned, sign/zero-extended load data to the pipeline.
- Sits between the MEM stage and the top-level data_sram_* interface.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (only 32 supported)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage has an access
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word
- req_unsigned  in  1  zero-extend load (ld.bu/ld.hu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- flush  in  1  pipeline flush (exception/ertn)
- resp_valid  out  1  access complete
- resp_ready  in  1  WB side accepts response
- resp_rdata  out  DATA_W  extended load data; 0 for stores
- resp_ale  out  1  address-misalign exception flag
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  bus write
- data_sram_size  out  2  bus size
- data_sram_wstrb  out  4  byte strobes
- data_sram_addr  out  ADDR_W  bus address
- data_sram_wdata  out  DATA_W  lane-replicated store data
- data_sram_addr_ok  in  1  address phase accepted
- data_sram_data_ok  in  1  data phase complete
- data_sram_rdata  in  DATA_W  raw read word

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset: state IDLE, cancel flag 0, all outputs 0 except req_ready = 1.
- IDLE:
  - req_ready = 1.
  - On req_valid & ~flush: latch we/size/unsigned/addr/wdata, then go to REQ.
  - If the request is misaligned (only with MEM_ALE_EN): go directly to RESP with resp_ale = 1.
  - req_valid & flush: nothing is accepted.
- REQ:
  - data_sram_req = 1; all bus fields come from registers and stay stable until addr_ok.
  - The request is never withdrawn.
  - On addr_ok, go to WAIT.
  - If addr_ok and data_ok arrive in the same cycle, treat it as addr_ok followed by data_ok in the same cycle: go straight to RESP, or to IDLE if cancelled.
- WAIT: on data_ok, capture the extended rdata and go to RESP; go to IDLE instead if the cancel flag is set.
- RESP: resp_valid = 1 with outputs held until resp_ready, then go to IDLE.
- Minimum latency: accept at cycle 0, data_sram_req at cycle 1, resp_valid at cycle 2 when addr_ok and data_ok arrive in the same cycle.
- Flush:
  - In REQ or WAIT: set the cancel flag. The bus transaction still completes and data_ok is consumed, but no response is produced.
  - In RESP: drop the response and go to IDLE.
  - The cancel flag clears on entering IDLE.
- Strobes (addr[1:0] = a):
  - byte: one-hot 1<<a.
  - half: a = 0 gives 0011, a = 2 gives 1100, odd a gives 0000.
  - word: 1111.
  - Loads drive wstrb = 0000.
- wdata lanes:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
- rdata extraction: byte = rdata >> (8*a); half = rdata >> (8*a) with a in {0,2}. Then sign- or zero-extend per req_unsigned.
- data_sram_size is set equal to req_size.
- data_sram_addr is the full byte address.
- Reset asserted mid-transaction returns to IDLE immediately. An outstanding data_ok after reset is ignored.

Optional Feature:
- MEM_ALE_EN defined: a misaligned access (half with a odd, word with a ≠ 0) never reaches the bus. It produces resp_valid with resp_ale = 1 and resp_rdata = 0 one cycle after accept.
- MEM_ALE_EN undefined: resp_ale is tied to 0, and misaligned accesses go to the bus with the strobes computed above (possibly 0000).

Decomposition:
- Shared package/header `mem_defs`:
  - size encodings MEM_B/MEM_H/MEM_W
  - FSM state encodings
- One natural sub-module, `mem_lane_align` (combinational), with inputs size, addr[1:0], wdata, rdata, unsigned and outputs wstrb, wdata_rep, rdata_ext.

Test Plan:
- Store byte: addr 0x1C000003, wdata 0x000000AB → wstrb 1000, data_sram_wdata 0xABABABAB, wr = 1; resp_valid after data_ok.
- Load half signed: addr 0x...02, rdata 0x8001_1234 → resp_rdata 0xFFFF8001. Same case with req_unsigned = 1 → 0x00008001.
- Bus stall: hold addr_ok low for 5 cycles → data_sram_req and all bus fields stay constant, req_ready = 0 throughout.
- Flush in WAIT: flush while waiting, data_ok 3 cycles later → no resp_valid; the FSM is back in IDLE and accepts the next request on the following cycle.
- Misaligned word load at addr 0x...01 with MEM_ALE_EN: no data_sram_req; resp_ale = 1 and resp_valid one cycle after accept.
- Back-to-back: addr_ok and data_ok both asserted in the same cycle as REQ, resp_ready held high → each access completes in 3 cycles; a mid-REQ reset returns req_ready = 1 on the next cycle.
